// File: rtl/mastermind_pkg.sv
// Shared types and defaults for the Mastermind board: FSM states, counter and
// peg widths used by the round controller and its neighbours.
package mastermind_pkg;

   localparam int unsigned NUM_SLOTS_DEF   = 4;
   localparam int unsigned MAX_GUESSES_DEF = 8;
   localparam int unsigned SYM_W_DEF       = 3;
   localparam int unsigned PEG_W           = 3;
   localparam int unsigned SLOT_W          = 2;
   localparam int unsigned GCNT_W          = 4;

   typedef enum logic [2:0] {
      ST_CODE       = 3'd0,
      ST_GUESS      = 3'd1,
      ST_SCORE_REQ  = 3'd2,
      ST_SCORE_WAIT = 3'd3,
      ST_JUDGE      = 3'd4,
      ST_WIN        = 3'd5,
      ST_LOSE       = 3'd6
   } state_e;

endpackage

// File: rtl/mastermind_round_ctrl_if.sv
// Board-side bundle for the round controller: player keys, scoring-engine
// handshake, register write strobes and status outputs.
interface mastermind_round_ctrl_if;
   import mastermind_pkg::*;

   logic              load;
   logic              new_game;
   logic              score_done;
   logic [PEG_W-1:0]  red_in;
   logic [PEG_W-1:0]  white_in;
   logic              code_we;
   logic              guess_we;
   logic [SLOT_W-1:0] slot_idx;
   logic              score_start;
   logic [PEG_W-1:0]  red_out;
   logic [PEG_W-1:0]  white_out;
   logic [GCNT_W-1:0] guess_count;
   logic              win;
   logic              lose;
   logic              busy;

   // The round controller owns the strobes and status.
   modport master (
      input  load, new_game, score_done, red_in, white_in,
      output code_we, guess_we, slot_idx, score_start,
      output red_out, white_out, guess_count, win, lose, busy
   );

   modport slave (
      output load, new_game, score_done, red_in, white_in,
      input  code_we, guess_we, slot_idx, score_start,
      input  red_out, white_out, guess_count, win, lose, busy
   );

endinterface

// File: rtl/mastermind_round_ctrl_btn_edge.sv
// Registers a synchronised key level and emits a one-cycle pulse on its rising
// edge; shared by the board's KEY inputs.
module mastermind_round_ctrl_btn_edge (
   input  logic clk,
   input  logic resetn,
   input  logic btn,
   output logic press
);

   logic btn_q;
   logic btn_d;

   // Next value of the delayed key level, cleared by reset.
   always_comb begin
      if (!resetn) begin
         btn_d = 1'b0;
      end else begin
         btn_d = btn;
      end
   end

   // Delayed key level register.
   always_ff @(posedge clk) begin
      btn_q <= btn_d;
   end

   assign press = btn & ~btn_q;

endmodule

// File: rtl/mastermind_round_ctrl.sv
// Mastermind round sequencer: turns load presses into code/guess slot writes,
// runs the scoring handshake, latches feedback and decides win or lose.
module mastermind_round_ctrl
   import mastermind_pkg::*;
#(
   parameter int unsigned NUM_SLOTS   = NUM_SLOTS_DEF,
   parameter int unsigned MAX_GUESSES = MAX_GUESSES_DEF,
   parameter int unsigned SYM_W       = SYM_W_DEF
) (
   input logic                     clk,
   input logic                     resetn,
   mastermind_round_ctrl_if.master bus
);

   state_e            state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [GCNT_W-1:0] gcnt_q, gcnt_d;
   logic [PEG_W-1:0]  red_q, red_d;
   logic [PEG_W-1:0]  white_q, white_d;
   logic              press_s;
   logic              last_slot_s;
   logic              code_we_s;
   logic              guess_we_s;
   logic              start_s;

   // Symbol width matters only to the external code/guess registers.
   if (SYM_W == 0) begin : g_sym_w_zero
   end

   mastermind_round_ctrl_btn_edge u_load_edge (
      .clk    (clk),
      .resetn (resetn),
      .btn    (bus.load),
      .press  (press_s)
   );

   assign last_slot_s = (slot_q == SLOT_W'(NUM_SLOTS - 1));

   // Next-state, counters and write strobes; reset overrides everything last.
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      gcnt_d     = gcnt_q;
      red_d      = red_q;
      white_d    = white_q;
      code_we_s  = 1'b0;
      guess_we_s = 1'b0;
      start_s    = 1'b0;
      case (state_q)
         ST_CODE, ST_GUESS: begin
            if (press_s) begin
               code_we_s  = (state_q == ST_CODE);
               guess_we_s = (state_q == ST_GUESS);
               if (last_slot_s) begin
                  slot_d  = {SLOT_W{1'b0}};
                  state_d = (state_q == ST_CODE) ? ST_GUESS : ST_SCORE_REQ;
               end else begin
                  slot_d = slot_q + SLOT_W'(1);
               end
            end else begin
               slot_d = slot_q;
            end
         end
         ST_SCORE_REQ: begin
            start_s = 1'b1;
            state_d = ST_SCORE_WAIT;
         end
         ST_SCORE_WAIT: begin
            if (bus.score_done) begin
               red_d   = bus.red_in;
               white_d = bus.white_in;
               state_d = ST_JUDGE;
               if (gcnt_q < GCNT_W'(MAX_GUESSES)) begin
                  gcnt_d = gcnt_q + GCNT_W'(1);
               end else begin
                  gcnt_d = gcnt_q;
               end
            end else begin
               state_d = ST_SCORE_WAIT;
            end
         end
         ST_JUDGE: begin
            // A full red score wins even on the final allowed guess.
            if (red_q == PEG_W'(NUM_SLOTS)) begin
               state_d = ST_WIN;
            end else if (gcnt_q == GCNT_W'(MAX_GUESSES)) begin
               state_d = ST_LOSE;
            end else begin
               state_d = ST_GUESS;
               slot_d  = {SLOT_W{1'b0}};
            end
         end
         ST_WIN, ST_LOSE: begin
            if (bus.new_game) begin
               state_d = ST_CODE;
               slot_d  = {SLOT_W{1'b0}};
               gcnt_d  = {GCNT_W{1'b0}};
               red_d   = {PEG_W{1'b0}};
               white_d = {PEG_W{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_CODE;
            slot_d  = {SLOT_W{1'b0}};
         end
      endcase
      if (!resetn) begin
         state_d    = ST_CODE;
         slot_d     = {SLOT_W{1'b0}};
         gcnt_d     = {GCNT_W{1'b0}};
         red_d      = {PEG_W{1'b0}};
         white_d    = {PEG_W{1'b0}};
         code_we_s  = 1'b0;
         guess_we_s = 1'b0;
         start_s    = 1'b0;
      end else begin
         state_d = state_d;
      end
   end

   // Round state, slot pointer, guess counter and latched feedback.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      slot_q  <= slot_d;
      gcnt_q  <= gcnt_d;
      red_q   <= red_d;
      white_q <= white_d;
   end

   assign bus.code_we     = code_we_s;
   assign bus.guess_we    = guess_we_s;
   assign bus.slot_idx    = slot_q;
   assign bus.score_start = start_s;
   assign bus.red_out     = red_q;
   assign bus.white_out   = white_q;
   assign bus.guess_count = gcnt_q;
   assign bus.win         = (state_q == ST_WIN);
   assign bus.lose        = (state_q == ST_LOSE);
   assign bus.busy        = (state_q == ST_SCORE_REQ) || (state_q == ST_SCORE_WAIT);

endmodule

// File: tb/tb_mastermind_round_ctrl.sv
// Self-checking bench for mastermind_round_ctrl: directed corner sequences,
// a first-guess vector table and randomized games against a game-level model.
module tb_mastermind_round_ctrl;
   import mastermind_pkg::*;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   mastermind_round_ctrl_if bus ();

   mastermind_round_ctrl #(.NUM_SLOTS(4), .MAX_GUESSES(8), .SYM_W(3)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc_no = 0;
   int code_cnt = 0;
   int guess_cnt = 0;
   int start_cnt = 0;
   int start_cyc = 0;
   int last_guess_cyc = 0;
   int code_slots[$];
   int guess_slots[$];

   always @(posedge clk) cyc_no <= cyc_no + 1;

   // Strobe monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (bus.code_we === 1'b1) begin
         code_cnt++;
         code_slots.push_back(int'(bus.slot_idx));
      end
      if (bus.guess_we === 1'b1) begin
         guess_cnt++;
         guess_slots.push_back(int'(bus.slot_idx));
         last_guess_cyc = cyc_no;
      end
      if (bus.score_start === 1'b1) begin
         start_cnt++;
         start_cyc = cyc_no;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic press(input int hold);
      bus.load = 1'b1;
      cyc(hold);
      bus.load = 1'b0;
      cyc(1);
   endtask

   task automatic enter(input int n);
      for (int i = 0; i < n; i++) press(int'($urandom_range(1, 4)));
   endtask

   task automatic reset_dut();
      resetn       = 1'b0;
      bus.load     = 1'b0;
      bus.new_game = 1'b0;
      bus.score_done = 1'b0;
      cyc(2);
      resetn = 1'b1;
      cyc(1);
   endtask

   task automatic new_game_pulse();
      bus.new_game = 1'b1;
      cyc(1);
      bus.new_game = 1'b0;
      cyc(1);
   endtask

   task automatic spurious_done();
      bus.score_done = 1'b1;
      bus.red_in     = 3'd4;
      cyc(1);
      bus.score_done = 1'b0;
      bus.red_in     = 3'd0;
   endtask

   // n guess presses, then answer the scoring request after 'delay' wait cycles.
   task automatic guess_round(input int n, input logic [2:0] red, input logic [2:0] white,
                              input int delay);
      int   base_s;
      int   t;
      logic busy_all;
      base_s = start_cnt;
      enter(n);
      t = 0;
      while (start_cnt == base_s && t < 20) begin
         cyc(1);
         t++;
      end
      chk("score_start pulses", start_cnt - base_s, 1);
      chk("start latency", start_cyc - last_guess_cyc, 1);
      busy_all = 1'b1;
      for (int i = 0; i < delay; i++) begin
         busy_all &= bus.busy;
         cyc(1);
      end
      busy_all &= bus.busy;
      chk("busy in wait", busy_all, 1);
      bus.score_done = 1'b1;
      bus.red_in     = red;
      bus.white_in   = white;
      cyc(1);
      bus.score_done = 1'b0;
      bus.red_in     = 3'd0;
      bus.white_in   = 3'd0;
      chk("judge latency", {bus.win, bus.lose}, 0);
      cyc(1);
   endtask

   typedef struct {
      logic [2:0] red;
      logic [2:0] white;
      logic       win;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int b_code, b_guess, b_start;
      logic [2:0] reds[8];
      logic [2:0] whites[8];
      int n_exp;
      logic won;
      int win_at;

      vecs[0] = '{red: 3'd2, white: 3'd1, win: 1'b0};
      vecs[1] = '{red: 3'd4, white: 3'd0, win: 1'b1};
      vecs[2] = '{red: 3'd0, white: 3'd0, win: 1'b0};
      vecs[3] = '{red: 3'd3, white: 3'd1, win: 1'b0};
      vecs[4] = '{red: 3'd0, white: 3'd4, win: 1'b0};
      vecs[5] = '{red: 3'd5, white: 3'd0, win: 1'b0};
      vecs[6] = '{red: 3'd7, white: 3'd2, win: 1'b0};

      resetn = 1'b0;
      bus.load = 1'b0;
      bus.new_game = 1'b0;
      bus.score_done = 1'b0;
      bus.red_in = 3'd0;
      bus.white_in = 3'd0;

      // Test 1: reset with load held, then four long code presses.
      bus.load = 1'b1;
      cyc(1);
      chk("code_we in reset", bus.code_we, 0);
      bus.load = 1'b0;
      cyc(1);
      resetn = 1'b1;
      cyc(1);
      chk("reset win", bus.win, 0);
      chk("reset lose", bus.lose, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset guess_count", bus.guess_count, 0);
      chk("reset red_out", bus.red_out, 0);
      chk("reset white_out", bus.white_out, 0);
      b_code = code_cnt; b_guess = guess_cnt;
      for (int i = 0; i < 4; i++) press(5);
      chk("code_we pulses", code_cnt - b_code, 4);
      chk("guess_we during code", guess_cnt - b_guess, 0);
      for (int i = 0; i < 4; i++) chk("code slot", code_slots[b_code + i], i);

      // Test 2: first guess with a 10-cycle scoring wait.
      b_guess = guess_cnt;
      guess_round(4, 3'd2, 3'd1, 10);
      chk("t2 red_out", bus.red_out, 2);
      chk("t2 white_out", bus.white_out, 1);
      chk("t2 guess_count", bus.guess_count, 1);
      chk("t2 win/lose", {bus.win, bus.lose}, 0);
      for (int i = 0; i < 4; i++) chk("guess slot", guess_slots[b_guess + i], i);
      b_guess = guess_cnt;
      press(2);
      chk("next guess slot 0", guess_slots[b_guess], 0);

      // Test 3: winning guess, ignored presses, new game.
      guess_round(3, 3'd4, 3'd0, 2);
      chk("t3 win", bus.win, 1);
      chk("t3 guess_count", bus.guess_count, 2);
      b_code = code_cnt; b_guess = guess_cnt; b_start = start_cnt;
      enter(3);
      spurious_done();
      cyc(3);
      chk("t3 no strobes after win", (code_cnt - b_code) + (guess_cnt - b_guess) + (start_cnt - b_start), 0);
      chk("t3 win held", bus.win, 1);
      new_game_pulse();
      chk("t3 new_game win", bus.win, 0);
      chk("t3 new_game guess_count", bus.guess_count, 0);
      chk("t3 new_game red_out", bus.red_out, 0);
      chk("t3 new_game white_out", bus.white_out, 0);
      b_code = code_cnt;
      enter(4);
      chk("t3 code after new_game", code_cnt - b_code, 4);
      chk("t3 code slot 0", code_slots[b_code], 0);

      // Test 4: eight misses lose, no ninth scoring request.
      for (int g = 0; g < 8; g++) guess_round(4, 3'd1, 3'd2, g % 3);
      chk("t4 lose", bus.lose, 1);
      chk("t4 win", bus.win, 0);
      chk("t4 guess_count", bus.guess_count, 8);
      chk("t4 red_out", bus.red_out, 1);
      b_start = start_cnt; b_guess = guess_cnt;
      enter(4);
      cyc(4);
      chk("t4 no 9th start", start_cnt - b_start, 0);
      chk("t4 no guess strobes", guess_cnt - b_guess, 0);

      // Test 5: win on the eighth guess beats lose.
      new_game_pulse();
      enter(4);
      for (int g = 0; g < 7; g++) guess_round(4, 3'd0, 3'd1, 1);
      guess_round(4, 3'd4, 3'd0, 3);
      chk("t5 win", bus.win, 1);
      chk("t5 lose", bus.lose, 0);
      chk("t5 guess_count", bus.guess_count, 8);

      // Test 6: reset during the scoring wait, then late score_done.
      new_game_pulse();
      enter(4);
      enter(4);
      cyc(2);
      chk("t6 busy before reset", bus.busy, 1);
      resetn = 1'b0;
      cyc(1);
      resetn = 1'b1;
      spurious_done();
      cyc(3);
      chk("t6 win", bus.win, 0);
      chk("t6 busy", bus.busy, 0);
      chk("t6 guess_count", bus.guess_count, 0);
      chk("t6 red_out", bus.red_out, 0);
      b_code = code_cnt;
      enter(4);
      chk("t6 code after reset", code_cnt - b_code, 4);
      chk("t6 code slot 0", code_slots[b_code], 0);
      press(1);
      b_guess = guess_cnt;
      spurious_done();
      press(50);
      chk("t6 single strobe held", guess_cnt - b_guess, 1);
      chk("t6 held strobe slot", guess_slots[b_guess], 1);
      chk("t6 done in guess ignored", {bus.win, bus.busy, bus.guess_count}, 0);

      // First-guess vector table.
      for (int v = 0; v < 7; v++) begin
         reset_dut();
         enter(4);
         guess_round(4, vecs[v].red, vecs[v].white, v);
         chk("vec win", bus.win, vecs[v].win);
         chk("vec lose", bus.lose, 0);
         chk("vec red_out", bus.red_out, vecs[v].red);
         chk("vec white_out", bus.white_out, vecs[v].white);
         chk("vec guess_count", bus.guess_count, 1);
      end

      // Randomized games against the game-level model.
      for (int g = 0; g < 8; g++) begin
         win_at = int'($urandom_range(0, 11));
         for (int i = 0; i < 8; i++) begin
            reds[i]   = 3'($urandom_range(0, 3));
            whites[i] = 3'($urandom_range(0, 4));
         end
         if (win_at < 8) reds[win_at] = 3'd4;
         n_exp = 8;
         won   = 1'b0;
         for (int i = 7; i >= 0; i--) begin
            if (reds[i] == 3'd4) begin
               n_exp = i + 1;
               won   = 1'b1;
            end
         end
         reset_dut();
         b_code = code_cnt; b_guess = guess_cnt; b_start = start_cnt;
         enter(4);
         for (int i = 0; i < n_exp; i++) begin
            if ($urandom_range(0, 1) == 1) spurious_done();
            guess_round(4, reds[i], whites[i], int'($urandom_range(0, 6)));
         end
         chk("rand win", bus.win, won);
         chk("rand lose", bus.lose, !won);
         chk("rand guess_count", bus.guess_count, n_exp);
         chk("rand red_out", bus.red_out, reds[n_exp - 1]);
         chk("rand white_out", bus.white_out, whites[n_exp - 1]);
         chk("rand starts", start_cnt - b_start, n_exp);
         chk("rand guess strobes", guess_cnt - b_guess, 4 * n_exp);
         chk("rand code strobes", code_cnt - b_code, 4);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
